// File: rtl/shift_serializer_pkg.sv
// Shared definitions for the serializer feeding the 4-bit serial-in shift register:
// FSM encoding, counter-width helper and the default word width.
package shift_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 4;

   // Bits needed to hold values 0..n-1; never less than 1.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/shift_serializer_hold_buf.sv
// One-entry holding slot for the next word to serialize.
// Latency: written word visible on rdata the cycle after wr.
// Backpressure: writer must not write while full; rd clears full at the edge.
module tx_hold_buf #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd,
   output logic [WIDTH-1:0] rdata,
   output logic             full
);

   always_ff @(posedge clk) begin
      if (rst) begin
         full  <= 1'b0;
         rdata <= '0;
      end else if (wr) begin
         full  <= 1'b1;
         rdata <= wdata;
      end else if (rd) begin
         full  <= 1'b0;
      end
   end

endmodule

// File: rtl/shift_serializer.sv
// Parallel-to-serial stage: WIDTH-bit words in over valid/ready, one bit per clk out.
// Latency: first bit on sout the cycle after the accepting edge; GAP idle cycles between words.
// Backpressure: din_ready drops only while the one-entry hold slot is occupied (or in reset).
module shift_serializer
   import shift_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int GAP       = 1,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             frame,
   output logic             word_done,
   output logic             busy
);

   localparam int CW = clog2(WIDTH);
   localparam int GW = (GAP > 1) ? clog2(GAP) : 1;
   localparam logic [CW-1:0] CNT_FIRST = CW'(WIDTH - 1);

   state_t           state, state_nx;
   logic [WIDTH-1:0] shreg, shreg_nx, shifted;
   logic [CW-1:0]    cnt, cnt_nx;
   logic [GW-1:0]    gcnt, gcnt_nx;
   logic             accept, sel;
   logic             hold_wr, hold_rd, hold_full;
   logic [WIDTH-1:0] hold_data;

   tx_hold_buf #(.WIDTH(WIDTH)) u_hold (
      .clk   (clk),
      .rst   (rst),
      .wr    (hold_wr),
      .wdata (din),
      .rd    (hold_rd),
      .rdata (hold_data),
      .full  (hold_full)
   );

   assign din_ready = !hold_full && !rst;
   assign accept    = din_valid && din_ready;
   assign shifted   = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         shreg <= '0;
         cnt   <= '0;
         gcnt  <= '0;
      end else begin
         state <= state_nx;
         shreg <= shreg_nx;
         cnt   <= cnt_nx;
         gcnt  <= gcnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      shreg_nx = shreg;
      cnt_nx   = cnt;
      gcnt_nx  = gcnt;
      hold_wr  = 1'b0;
      hold_rd  = 1'b0;
      sel      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               shreg_nx = din;
               cnt_nx   = CNT_FIRST;
               state_nx = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            shreg_nx = shifted;
            hold_wr  = accept;
            if (cnt != '0) begin
               cnt_nx = cnt - 1'b1;
            end else if (GAP > 0) begin
               state_nx = ST_GAP;
               gcnt_nx  = GW'(GAP - 1);
            end else begin
               sel = 1'b1;
            end
         end
         ST_GAP: begin
            hold_wr = accept;
            if (gcnt != '0) gcnt_nx = gcnt - 1'b1;
            else            sel     = 1'b1;
         end
         default: state_nx = ST_IDLE;
      endcase

      // The held word wins; with the slot empty a word offered right now goes straight in.
      if (sel) begin
         if (hold_full) begin
            hold_rd  = 1'b1;
            shreg_nx = hold_data;
            cnt_nx   = CNT_FIRST;
            state_nx = ST_SHIFT;
         end else if (accept) begin
            hold_wr  = 1'b0;
            shreg_nx = din;
            cnt_nx   = CNT_FIRST;
            state_nx = ST_SHIFT;
         end else begin
            state_nx = ST_IDLE;
         end
      end
   end

   assign sout_valid = (state == ST_SHIFT);
   assign sout       = sout_valid && ((MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0]);
   assign frame      = sout_valid && (cnt == CNT_FIRST);
   assign word_done  = sout_valid && (cnt == '0);
   assign busy       = (state != ST_IDLE) || hold_full;

endmodule

// File: tb/tb_shift_serializer.sv
// Bench for shift_serializer: three configurations (GAP=1 MSB, GAP=0 MSB, GAP=1 LSB)
// driven from vector tables, hand sequences and a randomized scoreboard run.
module tb_shift_serializer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [3:0] din_a, din_b, din_c;
   logic       vld_a, vld_b, vld_c;
   logic       rdy_a, rdy_b, rdy_c;
   logic       sout_a, sout_b, sout_c;
   logic       sv_a, sv_b, sv_c;
   logic       fr_a, fr_b, fr_c;
   logic       wd_a, wd_b, wd_c;
   logic       busy_a, busy_b, busy_c;

   shift_serializer #(.WIDTH(4), .GAP(1), .MSB_FIRST(1)) dut_a (
      .clk(clk), .rst(rst), .din(din_a), .din_valid(vld_a), .din_ready(rdy_a),
      .sout(sout_a), .sout_valid(sv_a), .frame(fr_a), .word_done(wd_a), .busy(busy_a));
   shift_serializer #(.WIDTH(4), .GAP(0), .MSB_FIRST(1)) dut_b (
      .clk(clk), .rst(rst), .din(din_b), .din_valid(vld_b), .din_ready(rdy_b),
      .sout(sout_b), .sout_valid(sv_b), .frame(fr_b), .word_done(wd_b), .busy(busy_b));
   shift_serializer #(.WIDTH(4), .GAP(1), .MSB_FIRST(0)) dut_c (
      .clk(clk), .rst(rst), .din(din_c), .din_valid(vld_c), .din_ready(rdy_c),
      .sout(sout_c), .sout_valid(sv_c), .frame(fr_c), .word_done(wd_c), .busy(busy_c));

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model of the downstream 4-bit serial-in shift register.
   logic [3:0] sr_a;
   always @(posedge clk) begin
      if (rst)       sr_a <= 4'h0;
      else if (sv_a) sr_a <= {sr_a[2:0], sout_a};
   end

   // Scoreboard: words pushed on accept, reassembled from sout and popped on word_done.
   logic [3:0] sbq[$];
   logic       mon_en = 1'b0;
   logic [3:0] acc;
   int         nb;
   int         wdone = 0;
   logic [3:0] expw;

   always @(negedge clk) begin
      if (mon_en) begin
         if (vld_a && rdy_a) sbq.push_back(din_a);
         if (!sv_a) chk("t6_idle_sout", {31'd0, sout_a}, 32'd0);
         else begin
            if (fr_a) begin
               acc = 4'h0;
               nb  = 0;
            end
            acc = {acc[2:0], sout_a};
            nb++;
            if (wd_a) begin
               wdone++;
               if (sbq.size() == 0) chk("t6_extra_word", 32'd1, 32'd0);
               else begin
                  expw = sbq.pop_front();
                  chk("t6_word", {28'd0, acc}, {28'd0, expw});
                  chk("t6_bits", nb, 32'd4);
               end
            end
         end
      end
   end

   typedef struct {
      logic [3:0] din;
      logic       vld;
      logic [5:0] exp;      // {sout, sout_valid, frame, word_done, busy, din_ready}
      logic       sr_chk;
      logic [3:0] sr_exp;
   } vec_t;

   vec_t vt[19];

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      int guard;
      int quiet;
      logic [3:0] nxt;
      logic [7:0] bits8;

      // Test 1 (GAP=1) followed by test 5 (accept in the final gap cycle).
      vt[0]  = '{4'b1011, 1'b1, 6'b000001, 1'b0, 4'h0};
      vt[1]  = '{4'b0000, 1'b0, 6'b111011, 1'b0, 4'h0};
      vt[2]  = '{4'b0000, 1'b0, 6'b010011, 1'b0, 4'h0};
      vt[3]  = '{4'b0000, 1'b0, 6'b110011, 1'b0, 4'h0};
      vt[4]  = '{4'b0000, 1'b0, 6'b110111, 1'b0, 4'h0};
      vt[5]  = '{4'b0000, 1'b0, 6'b000011, 1'b0, 4'h0};
      vt[6]  = '{4'b0000, 1'b0, 6'b000001, 1'b1, 4'b1011};
      vt[7]  = '{4'b1100, 1'b1, 6'b000001, 1'b0, 4'h0};
      vt[8]  = '{4'b0000, 1'b0, 6'b111011, 1'b0, 4'h0};
      vt[9]  = '{4'b0000, 1'b0, 6'b110011, 1'b0, 4'h0};
      vt[10] = '{4'b0000, 1'b0, 6'b010011, 1'b0, 4'h0};
      vt[11] = '{4'b0000, 1'b0, 6'b010111, 1'b0, 4'h0};
      vt[12] = '{4'b0110, 1'b1, 6'b000011, 1'b0, 4'h0};
      vt[13] = '{4'b0000, 1'b0, 6'b011011, 1'b0, 4'h0};
      vt[14] = '{4'b0000, 1'b0, 6'b110011, 1'b0, 4'h0};
      vt[15] = '{4'b0000, 1'b0, 6'b110011, 1'b0, 4'h0};
      vt[16] = '{4'b0000, 1'b0, 6'b010111, 1'b0, 4'h0};
      vt[17] = '{4'b0000, 1'b0, 6'b000011, 1'b0, 4'h0};
      vt[18] = '{4'b0000, 1'b0, 6'b000001, 1'b1, 4'b0110};

      rst = 1'b1;
      din_a = 4'h0; din_b = 4'h0; din_c = 4'h0;
      vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;
      tick();
      tick();
      @(negedge clk);
      chk("rst_a", {26'd0, sout_a, sv_a, fr_a, wd_a, busy_a, rdy_a}, 32'd0);
      chk("rst_b", {26'd0, sout_b, sv_b, fr_b, wd_b, busy_b, rdy_b}, 32'd0);
      chk("rst_c", {26'd0, sout_c, sv_c, fr_c, wd_c, busy_c, rdy_c}, 32'd0);
      tick();
      rst = 1'b0;

      for (int i = 0; i < 19; i++) begin
         din_a = vt[i].din;
         vld_a = vt[i].vld;
         @(negedge clk);
         chk($sformatf("vec%0d", i), {26'd0, sout_a, sv_a, fr_a, wd_a, busy_a, rdy_a},
             {26'd0, vt[i].exp});
         if (vt[i].sr_chk) chk($sformatf("vec%0d_sr", i), {28'd0, sr_a}, {28'd0, vt[i].sr_exp});
         tick();
      end

      // Test 4: reset during the second bit of 4'hF with 4'h3 in the hold slot.
      din_a = 4'hF; vld_a = 1'b1;
      tick();
      din_a = 4'h3;
      @(negedge clk);
      chk("t4_rdy_before_hold", {31'd0, rdy_a}, 32'd1);
      tick();
      vld_a = 1'b0;
      chk("t4_hold_full", {29'd0, sv_a, fr_a, rdy_a}, 32'b100);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t4_after_rst", {28'd0, sv_a, busy_a, wd_a, rdy_a}, 32'b0001);
      quiet = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (sv_a || wd_a || busy_a) quiet++;
      end
      chk("t4_no_held_word", quiet, 32'd0);

      // Test 2: GAP=0, two words back to back via the hold slot.
      tick();
      bits8 = 8'b1010_0101;
      din_b = 4'hA; vld_b = 1'b1;
      @(negedge clk);
      chk("t2_rdy0", {31'd0, rdy_b}, 32'd1);
      tick();
      din_b = 4'h5;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("t2_bit%0d", i), {28'd0, sout_b, sv_b, fr_b, wd_b},
             {28'd0, bits8[7-i], 1'b1, (i == 0 || i == 4), (i == 3 || i == 7)});
         chk($sformatf("t2_rdy%0d", i), {31'd0, rdy_b}, {31'd0, !(i >= 1 && i <= 3)});
         tick();
         if (i == 0) vld_b = 1'b0;
      end
      @(negedge clk);
      chk("t2_end", {30'd0, sv_b, busy_b}, 32'd0);

      // Test 3: LSB first.
      tick();
      din_c = 4'b0001; vld_c = 1'b1;
      tick();
      vld_c = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("t3_bit%0d", i), {29'd0, sout_c, sv_c, wd_c},
             {29'd0, (i == 0), 1'b1, (i == 3)});
         tick();
      end
      @(negedge clk);
      chk("t3_gap", {31'd0, sv_c}, 32'd0);

      // Test 6: random valid toggling, 200 words through the scoreboard.
      tick();
      sbq.delete();
      mon_en = 1'b1;
      sent  = 0;
      guard = 0;
      nxt   = 4'($urandom);
      while (sent < 200 && guard < 20000) begin
         if ($urandom_range(0, 2) != 0) begin
            vld_a = 1'b1;
            din_a = nxt;
         end else begin
            vld_a = 1'b0;
            din_a = 4'($urandom);
         end
         @(negedge clk);
         if (vld_a && rdy_a) begin
            sent++;
            nxt = 4'($urandom);
         end
         tick();
         guard++;
      end
      vld_a = 1'b0;
      for (int k = 0; k < 50 && busy_a; k++) tick();
      @(negedge clk);
      mon_en = 1'b0;
      chk("t6_sent", sent, 32'd200);
      chk("t6_done", wdone, 32'd200);
      chk("t6_left", sbq.size(), 32'd0);
      chk("t6_idle", {31'd0, busy_a}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
